// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: receiver codes, error bit
// positions, controller state encoding and a saturating counter helper.
package uart_pkg;

    localparam logic [1:0] BAUD_9600   = 2'd0;
    localparam logic [1:0] BAUD_19200  = 2'd1;
    localparam logic [1:0] BAUD_57600  = 2'd2;
    localparam logic [1:0] BAUD_115200 = 2'd3;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam int ERR_PAR   = 0;
    localparam int ERR_START = 1;
    localparam int ERR_STOP  = 2;

    localparam int FIFO_WIDTH = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_RUN    = 2'd2
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Small first-word-fall-through FIFO; head is read straight from the storage
// registers. Pointers carry one extra wrap bit to tell full from empty.
module rx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// Sequences the UART receiver (reset, baud/parity), captures completed frames into
// a FIFO presented as a valid/ready stream, and keeps overrun/error statistics.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int RST_CYC  = 4,
    parameter int DROP_ERR = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_enable_i,
    input  logic       cfg_write_i,
    input  logic [1:0] cfg_baud_i,
    input  logic [1:0] cfg_parity_i,
    input  logic       clear_status_i,
    input  logic       rx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic [2:0] rx_error_i,
    output logic       rx_resetn_o,
    output logic [1:0] baud_rate_o,
    output logic [1:0] parity_type_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic [2:0] out_error_o,
    output logic       overrun_o,
    output logic [7:0] overrun_cnt_o,
    output logic [7:0] err_cnt_o,
    output logic       busy_o
);

    localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rxdone_q;
    logic [1:0]      baud_q, parity_q;
    logic            overrun_q;
    logic [7:0]      ovr_cnt_q, err_cnt_q;

    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic            fifo_full, fifo_empty;
    logic            frame_ev, frame_err, drop_frame, push_req, pop, lost;

    assign frame_ev   = rx_done_i & ~rxdone_q & (state_q == ST_RUN);
    assign frame_err  = |rx_error_i;
    assign drop_frame = (DROP_ERR != 0) && frame_err;
    assign push_req   = frame_ev & ~drop_frame;
    assign pop        = ~fifo_empty & out_ready_i;
    assign lost       = push_req & fifo_full & ~pop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_resetn_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RESYNC;
                cnt_d   = CW'(RST_CYC - 1);
            end
            ST_RESYNC: begin
                busy_o = 1'b1;
                if (cfg_write_i) begin
                    cnt_d = CW'(RST_CYC - 1);
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                rx_resetn_o = 1'b1;
                if (cfg_write_i) begin
                    state_d = ST_RESYNC;
                    cnt_d   = CW'(RST_CYC - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Disabling the receiver overrides every other transition, including a reconfiguration.
        if (!rx_enable_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rxdone_q <= 1'b0;
            baud_q   <= '0;
            parity_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rxdone_q <= rx_done_i;
            if (cfg_write_i) begin
                baud_q   <= cfg_baud_i;
                parity_q <= cfg_parity_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
            ovr_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (clear_status_i) begin
            overrun_q <= 1'b0;
            ovr_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (lost) begin
                overrun_q <= 1'b1;
                ovr_cnt_q <= sat_inc8(ovr_cnt_q);
            end
            if (frame_ev && frame_err) begin
                err_cnt_q <= sat_inc8(err_cnt_q);
            end
        end
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .din_i   ({rx_error_i, rx_data_i}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_rate_o   = baud_q;
    assign parity_type_o = parity_q;
    assign out_valid_o   = ~fifo_empty;
    assign out_data_o    = fifo_dout[7:0];
    assign out_error_o   = fifo_dout[10:8];
    assign overrun_o     = overrun_q;
    assign overrun_cnt_o = ovr_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: directed vector table, hand sequences for corner
// cases, then randomized traffic against a queue-based reference model.
module tb_uart_rx_controller;

    localparam int DEPTH   = 4;
    localparam int RST_CYC = 4;

    logic       clk = 1'b0;
    logic       rst, en, cfg, clr, done, ready;
    logic [1:0] cbaud, cpar;
    logic [7:0] data;
    logic [2:0] err;

    logic       resetn0, valid0, ovr0, busy0;
    logic [1:0] baud0, par0;
    logic [7:0] dout0, ovc0, errc0;
    logic [2:0] derr0;
    logic       resetn1, valid1, ovr1, busy1;
    logic [1:0] baud1, par1;
    logic [7:0] dout1, ovc1, errc1;
    logic [2:0] derr1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_controller #(.DEPTH(DEPTH), .RST_CYC(RST_CYC), .DROP_ERR(0)) dut (
        .clk_i(clk), .rst_i(rst), .rx_enable_i(en), .cfg_write_i(cfg),
        .cfg_baud_i(cbaud), .cfg_parity_i(cpar), .clear_status_i(clr),
        .rx_done_i(done), .rx_data_i(data), .rx_error_i(err),
        .rx_resetn_o(resetn0), .baud_rate_o(baud0), .parity_type_o(par0),
        .out_valid_o(valid0), .out_ready_i(ready), .out_data_o(dout0),
        .out_error_o(derr0), .overrun_o(ovr0), .overrun_cnt_o(ovc0),
        .err_cnt_o(errc0), .busy_o(busy0));

    uart_rx_controller #(.DEPTH(DEPTH), .RST_CYC(RST_CYC), .DROP_ERR(1)) dut_drop (
        .clk_i(clk), .rst_i(rst), .rx_enable_i(en), .cfg_write_i(cfg),
        .cfg_baud_i(cbaud), .cfg_parity_i(cpar), .clear_status_i(clr),
        .rx_done_i(done), .rx_data_i(data), .rx_error_i(err),
        .rx_resetn_o(resetn1), .baud_rate_o(baud1), .parity_type_o(par1),
        .out_valid_o(valid1), .out_ready_i(ready), .out_data_o(dout1),
        .out_error_o(derr1), .overrun_o(ovr1), .overrun_cnt_o(ovc1),
        .err_cnt_o(errc1), .busy_o(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic [2:0] e);
        done = 1'b1; data = d; err = e;
        step();
        done = 1'b0;
        step();
    endtask

    task automatic chk_reset();
        chk("rst_resetn", resetn0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_data", dout0, 0);
        chk("rst_error", derr0, 0);
        chk("rst_overrun", ovr0, 0);
        chk("rst_ovcnt", ovc0, 0);
        chk("rst_errcnt", errc0, 0);
        chk("rst_baud", baud0, 0);
        chk("rst_parity", par0, 0);
        chk("rst_valid_drop", valid1, 0);
    endtask

    // Directed vector table
    typedef struct {
        logic       en, done, ready;
        logic [7:0] data;
        logic [2:0] err;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_error;
        logic       exp_resetn, exp_busy, exp_ovr;
        logic [7:0] exp_ovc, exp_errc;
        logic       exp_valid_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e_n, input logic d_n, input logic [7:0] dat, input logic [2:0] er,
                       input logic rdy, input logic ev, input logic [7:0] ed, input logic [2:0] ee,
                       input logic rn, input logic bz, input logic ov, input logic [7:0] ovc,
                       input logic [7:0] ec, input logic evd);
        vec_t v;
        v.en = e_n; v.done = d_n; v.data = dat; v.err = er; v.ready = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_error = ee; v.exp_resetn = rn;
        v.exp_busy = bz; v.exp_ovr = ov; v.exp_ovc = ovc; v.exp_errc = ec; v.exp_valid_drop = evd;
        tbl.push_back(v);
    endtask

    // Reference model: a plain queue plus phase bookkeeping
    logic [10:0] mq[$];
    int m_phase, m_left, m_ovc, m_errc, m_baud, m_par;
    bit m_ovr, m_prev;

    task automatic model_reset();
        mq.delete();
        m_phase = 0; m_left = 0; m_ovc = 0; m_errc = 0; m_baud = 0; m_par = 0;
        m_ovr = 0; m_prev = 0;
    endtask

    task automatic model_edge();
        int  sz;
        bit  p, ev, e;
        sz = mq.size();
        p  = (sz > 0) && ready;
        ev = done && !m_prev && (m_phase == 2);
        e  = (err != 0);
        if (p) void'(mq.pop_front());
        if (ev) begin
            if (e && m_errc < 255) m_errc++;
            if (sz == DEPTH && !p) begin
                m_ovr = 1;
                if (m_ovc < 255) m_ovc++;
            end else begin
                mq.push_back({err, data});
            end
        end
        if (clr) begin
            m_ovr = 0; m_ovc = 0; m_errc = 0;
        end
        if (!en) m_phase = 0;
        else if (m_phase == 0) begin
            m_phase = 1; m_left = RST_CYC;
        end else if (m_phase == 1) begin
            if (cfg) m_left = RST_CYC;
            else begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else if (cfg) begin
            m_phase = 1; m_left = RST_CYC;
        end
        if (cfg) begin
            m_baud = cbaud; m_par = cpar;
        end
        m_prev = done;
    endtask

    initial begin
        rst = 1'b1; en = 0; cfg = 0; clr = 0; done = 0; ready = 0;
        cbaud = 0; cpar = 0; data = 0; err = 0;
        step();
        step();
        chk_reset();
        rst = 1'b0;

        // Startup, single frame, overrun with five frames, drain, error frame
        for (int i = 0; i < 4; i++) add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 8'hA5, 0, 1, 1, 8'hA5, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 8'hA5, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(1, 1, 8'(k), 0, 0, 1, 8'h01, 0, 1, 0, k == 5, (k == 5) ? 8'd1 : 8'd0, 0, 1);
            add(1, 0, 8'(k), 0, 0, 1, 8'h01, 0, 1, 0, k == 5, (k == 5) ? 8'd1 : 8'd0, 0, 1);
        end
        for (int j = 1; j <= 4; j++)
            add(1, 0, 8'h00, 0, 1, j < 4, 8'(j + 1), 0, 1, 0, 1, 1, 0, j < 4);
        add(1, 1, 8'h3C, 3'b001, 0, 1, 8'h3C, 3'b001, 1, 0, 1, 1, 1, 0);
        add(1, 0, 8'h3C, 3'b001, 0, 1, 8'h3C, 3'b001, 1, 0, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; done = tbl[i].done; data = tbl[i].data;
            err = tbl[i].err; ready = tbl[i].ready;
            step();
            chk($sformatf("v%0d_valid", i), valid0, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_data", i), dout0, tbl[i].exp_data);
                chk($sformatf("v%0d_error", i), derr0, tbl[i].exp_error);
            end
            chk($sformatf("v%0d_resetn", i), resetn0, tbl[i].exp_resetn);
            chk($sformatf("v%0d_busy", i), busy0, tbl[i].exp_busy);
            chk($sformatf("v%0d_overrun", i), ovr0, tbl[i].exp_ovr);
            chk($sformatf("v%0d_ovcnt", i), ovc0, tbl[i].exp_ovc);
            chk($sformatf("v%0d_errcnt", i), errc0, tbl[i].exp_errc);
            chk($sformatf("v%0d_valid_drop", i), valid1, tbl[i].exp_valid_drop);
            chk($sformatf("v%0d_errcnt_drop", i), errc1, tbl[i].exp_errc);
        end
        done = 0; ready = 0; err = 0; data = 0;

        // Clear status, then reconfigure while running; frames ignored during resync
        clr = 1; step(); clr = 0;
        chk("clr_overrun", ovr0, 0);
        chk("clr_ovcnt", ovc0, 0);
        chk("clr_errcnt", errc0, 0);
        cfg = 1; cbaud = 2'd2; cpar = 2'd1; step(); cfg = 0; cbaud = 0; cpar = 0;
        chk("cfg_baud", baud0, 2);
        chk("cfg_parity", par0, 1);
        chk("cfg_busy", busy0, 1);
        chk("cfg_resetn", resetn0, 0);
        for (int i = 1; i <= 3; i++) begin
            done = (i == 1); data = 8'h77; err = 3'b010;
            step();
            chk($sformatf("resync%0d_busy", i), busy0, 1);
        end
        done = 0; err = 0;
        step();
        chk("resync_end_resetn", resetn0, 1);
        chk("resync_end_busy", busy0, 0);
        chk("resync_ignored_valid", valid0, 0);
        chk("resync_ignored_errcnt", errc0, 0);

        // Full FIFO with pop and push in the same cycle; clear beats an overrun
        ready = 0;
        for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 0);
        chk("full_head", dout0, 8'h10);
        done = 1; data = 8'h14; ready = 1; step();
        chk("fullpop_valid", valid0, 1);
        chk("fullpop_head", dout0, 8'h11);
        chk("fullpop_overrun", ovr0, 0);
        chk("fullpop_ovcnt", ovc0, 0);
        done = 0; ready = 0; step();
        done = 1; data = 8'h15; err = 3'b100; clr = 1; step();
        chk("clrwin_overrun", ovr0, 0);
        chk("clrwin_ovcnt", ovc0, 0);
        chk("clrwin_errcnt", errc0, 0);
        done = 0; err = 0; clr = 0; step();
        ready = 1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_valid", j), valid0, 1);
            chk($sformatf("drain%0d_data", j), dout0, 8'h11 + 8'(j));
            step();
        end
        chk("drain_empty", valid0, 0);

        // Contents survive IDLE/RESYNC; reset mid-resync restores everything
        ready = 0;
        frame(8'h5A, 0);
        en = 0; step();
        chk("idle_resetn", resetn0, 0);
        chk("idle_busy", busy0, 0);
        chk("idle_retain_valid", valid0, 1);
        chk("idle_retain_data", dout0, 8'h5A);
        en = 1; step();
        chk("reen_busy", busy0, 1);
        step();
        #3 rst = 1'b1;
        #1 chk_reset();
        @(posedge clk);
        #1;
        en = 0; cfg = 0; clr = 0; done = 0; ready = 0; data = 0; err = 0;
        rst = 1'b0;

        // Randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            en    = ($urandom_range(99) < 97);
            cfg   = ($urandom_range(99) < 3);
            clr   = ($urandom_range(99) < 3);
            cbaud = 2'($urandom_range(3));
            cpar  = 2'($urandom_range(3));
            if ($urandom_range(99) < 35) done = ~done;
            data  = 8'($urandom);
            err   = ($urandom_range(3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ready = ($urandom_range(99) < 40);
            model_edge();
            step();
            chk("rnd_valid", valid0, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rnd_data", dout0, mq[0][7:0]);
                chk("rnd_error", derr0, mq[0][10:8]);
            end
            chk("rnd_resetn", resetn0, m_phase == 2);
            chk("rnd_busy", busy0, m_phase == 1);
            chk("rnd_baud", baud0, m_baud);
            chk("rnd_parity", par0, m_par);
            chk("rnd_overrun", ovr0, m_ovr);
            chk("rnd_ovcnt", ovc0, m_ovc);
            chk("rnd_errcnt", errc0, m_errc);
            chk("rnd_errcnt_drop", errc1, m_errc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
